// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 memory controller: memory-type tags, the
// register-file index map, the PC reset value and the controller state type.
package chip8_pkg;

  localparam int PROC_MEM_TYPE_COUNT = 2;
  localparam int PROC_MEM_TYPE_W     = $clog2(PROC_MEM_TYPE_COUNT);

  localparam logic [PROC_MEM_TYPE_W-1:0] PROC_MEM_TYPE_RAM = PROC_MEM_TYPE_W'(0);
  localparam logic [PROC_MEM_TYPE_W-1:0] PROC_MEM_TYPE_REG = PROC_MEM_TYPE_W'(1);

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_IH  = 5'd16;
  localparam logic [REG_IDX_W-1:0] REG_IL  = 5'd17;
  localparam logic [REG_IDX_W-1:0] REG_PCH = 5'd18;
  localparam logic [REG_IDX_W-1:0] REG_PCL = 5'd19;
  localparam logic [REG_IDX_W-1:0] REG_DT  = 5'd20;
  localparam logic [REG_IDX_W-1:0] REG_ST  = 5'd21;
  localparam logic [REG_IDX_W-1:0] REG_SP  = 5'd22;

  localparam logic [11:0] PC_RESET = 12'h200;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_t;

  // Power-on value of a register-file byte: only PCh is nonzero.
  function automatic logic [7:0] init_value(input logic [REG_IDX_W-1:0] idx);
    return (idx == REG_PCH) ? {4'h0, PC_RESET[11:8]} : 8'h00;
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM with a registered output stage (2-cycle read
// latency). Reset clears only the output pipeline; the array is never reset.
module xilinx_single_port_ram_read_first #(
  parameter int  RAM_WIDTH = 8,
  parameter int  RAM_DEPTH = 4128,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en_in,
  input  logic                 we_in,
  input  logic [AW-1:0]        addr_in,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_q1;
  logic [RAM_WIDTH-1:0] r_q2;

  always_ff @(posedge clk_in) begin
    if (en_in && we_in) begin
      r_mem[addr_in] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      if (en_in) begin
        r_q1 <= r_mem[addr_in];
      end
      r_q2 <= r_q1;
    end
  end

  assign data_out = r_q2;

endmodule

// File: rtl/chip8_memory.sv
// CHIP-8 memory controller: one BRAM holds program RAM followed by the register
// file; serves the processor port and a write-only loader port. Optional
// delay/sound timers are built when CHIP8_TIMERS_EN is defined.
module chip8_memory
  import chip8_pkg::*;
#(
  parameter int RAM_DEPTH = 4096,
  parameter int REG_COUNT = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [11:0]                proc_addr_in,
  input  logic [PROC_MEM_TYPE_W-1:0] proc_type_in,
  input  logic                       proc_we_in,
  input  logic                       proc_valid_in,
  input  logic [7:0]                 proc_data_in,
  output logic                       proc_ready_out,
  output logic                       proc_valid_out,
  output logic [7:0]                 proc_data_out,
  input  logic [11:0]                load_addr_in,
  input  logic [7:0]                 load_data_in,
  input  logic                       load_valid_in,
  output logic                       load_ready_out,
  input  logic                       timer_decr_in,
  output logic                       active_audio_out,
  output logic                       dbg_state_out
);

  // Handshake: a processor request is taken in any cycle where proc_valid_in
  // and proc_ready_out are both high; a loader write is taken when
  // load_valid_in and load_ready_out are both high. Reads answer with
  // proc_valid_out exactly two cycles later; writes give no response.

  localparam int DEPTH = RAM_DEPTH + REG_COUNT;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] REG_BASE = AW'(RAM_DEPTH);

  mem_state_t           r_state;
  logic [REG_IDX_W-1:0] r_sweep;
  logic                 r_proc_ready;
  logic                 r_rd_v1, r_rd_v2;
  logic                 r_ovr_v1, r_ovr_v2;
  logic [7:0]           r_ovr_d1, r_ovr_d2;

  logic                 w_run, w_accept, w_rd;
  logic                 w_is_reg, w_reg_ok, w_timer_hit, w_ovr;
  logic [REG_IDX_W-1:0] w_idx;
  logic [7:0]           w_ovr_d;
  logic                 w_ram_en, w_ram_we;
  logic [AW-1:0]        w_ram_addr;
  logic [7:0]           w_ram_din, w_ram_dout;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = w_run && proc_valid_in;
  assign w_rd     = w_accept && !proc_we_in;
  assign w_is_reg = (proc_type_in == PROC_MEM_TYPE_REG);
  assign w_reg_ok = (proc_addr_in[11:REG_IDX_W] == '0);
  assign w_idx    = proc_addr_in[REG_IDX_W-1:0];

`ifdef CHIP8_TIMERS_EN
  logic [7:0] r_dt, r_st;
  logic       r_audio;
  logic [7:0] w_dt_next, w_st_next;
  logic       w_dt_wr, w_st_wr;

  assign w_timer_hit = w_is_reg && w_reg_ok && (w_idx == REG_DT || w_idx == REG_ST);
  assign w_dt_wr     = w_accept && proc_we_in && w_is_reg && w_reg_ok && (w_idx == REG_DT);
  assign w_st_wr     = w_accept && proc_we_in && w_is_reg && w_reg_ok && (w_idx == REG_ST);

  // A processor write in the tick cycle wins; that timer skips this tick.
  always_comb begin
    w_dt_next = r_dt;
    w_st_next = r_st;
    if (w_dt_wr) begin
      w_dt_next = proc_data_in;
    end else if (timer_decr_in && r_dt != 8'd0) begin
      w_dt_next = r_dt - 8'd1;
    end
    if (w_st_wr) begin
      w_st_next = proc_data_in;
    end else if (timer_decr_in && r_st != 8'd0) begin
      w_st_next = r_st - 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || !w_run) begin
      r_dt    <= 8'h00;
      r_st    <= 8'h00;
      r_audio <= 1'b0;
    end else begin
      r_dt    <= w_dt_next;
      r_st    <= w_st_next;
      r_audio <= (w_st_next != 8'd0);
    end
  end

  assign w_ovr_d          = !w_reg_ok ? 8'h00 : ((w_idx == REG_DT) ? r_dt : r_st);
  assign active_audio_out = r_audio;
`else
  logic w_unused;
  assign w_unused         = timer_decr_in;
  assign w_timer_hit      = 1'b0;
  assign w_ovr_d          = 8'h00;
  assign active_audio_out = 1'b0;
`endif

  // Out-of-range REG indices and the timer flops bypass the BRAM contents.
  assign w_ovr = w_is_reg && (!w_reg_ok || w_timer_hit);

  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = '0;
    w_ram_din  = 8'h00;
    if (rst_in) begin
      w_ram_en = 1'b0;
    end else if (!w_run) begin
      w_ram_en   = 1'b1;
      w_ram_we   = 1'b1;
      w_ram_addr = REG_BASE + AW'(r_sweep);
      w_ram_din  = init_value(r_sweep);
    end else if (proc_valid_in) begin
      w_ram_en   = 1'b1;
      w_ram_we   = proc_we_in && !w_ovr;
      w_ram_addr = w_is_reg ? (REG_BASE + AW'(w_idx)) : AW'(proc_addr_in);
      w_ram_din  = proc_data_in;
    end else if (load_valid_in) begin
      w_ram_en   = 1'b1;
      w_ram_we   = 1'b1;
      w_ram_addr = AW'(load_addr_in);
      w_ram_din  = load_data_in;
    end
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH (8),
    .RAM_DEPTH (DEPTH)
  ) u_ram (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (w_ram_en),
    .we_in    (w_ram_we),
    .addr_in  (w_ram_addr),
    .data_in  (w_ram_din),
    .data_out (w_ram_dout)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= ST_INIT;
      r_sweep      <= '0;
      r_proc_ready <= 1'b0;
      r_rd_v1      <= 1'b0;
      r_rd_v2      <= 1'b0;
      r_ovr_v1     <= 1'b0;
      r_ovr_v2     <= 1'b0;
      r_ovr_d1     <= 8'h00;
      r_ovr_d2     <= 8'h00;
    end else begin
      r_rd_v1  <= w_rd;
      r_rd_v2  <= r_rd_v1;
      r_ovr_v1 <= w_rd && w_ovr;
      r_ovr_v2 <= r_ovr_v1;
      r_ovr_d1 <= w_ovr_d;
      r_ovr_d2 <= r_ovr_d1;
      case (r_state)
        ST_INIT: begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == '1) begin
            r_state      <= ST_RUN;
            r_proc_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_proc_ready <= 1'b1;
        end
      endcase
    end
  end

  assign proc_ready_out = r_proc_ready;
  assign proc_valid_out = r_rd_v2;
  assign proc_data_out  = r_ovr_v2 ? r_ovr_d2 : w_ram_dout;
  assign load_ready_out = w_run && load_valid_in && !proc_valid_in;
  assign dbg_state_out  = r_state;

endmodule
